// File: rtl/iram_loader_pkg.sv
// Shared constants and the FSM state type for the IRAM init loader.
// Imported by the loader top and its checksum accumulator.
package iram_loader_pkg;

  localparam int IRAM_AWIDTH = 9;
  localparam int IRAM_DWIDTH = 9;
  localparam int IRAM_DEPTH  = 512;
  localparam int CSUM_WIDTH  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_LO,
    LOAD_HI,
    WRITE,
    RD_ISSUE,
    RD_DRAIN,
    FINISH
  } loader_state_e;

endpackage

// File: rtl/iram_init_loader_if.sv
// Boot stream, control/status and both IRAM ports of the loader in one bundle.
// master = the loader's view; slave = the boot source plus the IRAM.
interface iram_init_loader_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 9
) ();

  logic              START;
  logic [AWIDTH:0]   WORDS;
  logic [7:0]        SDATA;
  logic              SVALID;
  logic              SREADY;
  logic [AWIDTH-1:0] INITADDR;
  logic [DWIDTH-1:0] INITDATA;
  logic              WENABLE;
  logic [AWIDTH-1:0] RADDR;
  logic              RENABLE;
  logic [DWIDTH-1:0] RD;
  logic              BUSY;
  logic              DONE;
  logic              ERROR;
  logic [15:0]       CHECKSUM;

  modport master (
    input  START, WORDS, SDATA, SVALID, RD,
    output SREADY, INITADDR, INITDATA, WENABLE, RADDR, RENABLE,
           BUSY, DONE, ERROR, CHECKSUM
  );

  modport slave (
    output START, WORDS, SDATA, SVALID, RD,
    input  SREADY, INITADDR, INITDATA, WENABLE, RADDR, RENABLE,
           BUSY, DONE, ERROR, CHECKSUM
  );

endinterface

// File: rtl/iram_init_loader_csum16.sv
// Wrapping 16-bit accumulator with synchronous clear and hold.
// Used once for the written-word sum and once for the readback sum.
module iram_csum16
  import iram_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_i,
  input  logic                  acc_i,
  input  logic [CSUM_WIDTH-1:0] data_i,
  output logic [CSUM_WIDTH-1:0] sum_o
);

  logic [CSUM_WIDTH-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (clr_i) begin
      sum_q <= '0;
    end else if (acc_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/iram_init_loader.sv
// Loads the instruction RAM from a byte stream (two bytes per 9-bit word)
// and optionally reads every word back to compare checksums.
module iram_init_loader
  import iram_loader_pkg::*;
#(
  parameter int AWIDTH = IRAM_AWIDTH,
  parameter int DWIDTH = IRAM_DWIDTH,
  parameter bit VERIFY = 1'b1
) (
  input  logic             RWCLK,
  input  logic             RESET,
  iram_init_loader_if.master bus
);

  localparam logic [AWIDTH:0]   DEPTH  = {1'b1, {AWIDTH{1'b0}}};
  localparam logic [AWIDTH:0]   N_ONE  = {{AWIDTH{1'b0}}, 1'b1};
  localparam logic [AWIDTH-1:0] RA_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};

  loader_state_e state_q, state_d;

  logic [AWIDTH:0]       words_q;
  logic [AWIDTH:0]       n_q;
  logic [7:0]            lo_q;
  logic [AWIDTH-1:0]     initaddr_q;
  logic [DWIDTH-1:0]     initdata_q;
  logic [AWIDTH-1:0]     raddr_q;
  logic                  rdvalid_q;
  logic                  baddone_q;
  logic                  err_q;

  logic                  sready;
  logic                  wenable;
  logic                  renable;
  logic                  finishing;
  logic                  startAccept;
  logic                  wordsLegal;
  logic                  lastWord;
  logic                  lastRead;
  logic                  verifyFail;
  logic [AWIDTH:0]       lastIdx;
  logic [CSUM_WIDTH-1:0] wsum;
  logic [CSUM_WIDTH-1:0] rsum;

  assign wordsLegal  = (bus.WORDS != '0) && (bus.WORDS <= DEPTH);
  assign startAccept = (state_q == IDLE) && bus.START;
  assign lastIdx     = words_q - N_ONE;
  assign lastWord    = (n_q == lastIdx);
  assign lastRead    = ({1'b0, raddr_q} == lastIdx);
  assign verifyFail  = VERIFY && (rsum != wsum);

  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sready    = 1'b0;
    wenable   = 1'b0;
    renable   = 1'b0;
    finishing = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START && wordsLegal) begin
          state_d = LOAD_LO;
        end
      end
      LOAD_LO: begin
        sready = 1'b1;
        if (bus.SVALID) begin
          state_d = LOAD_HI;
        end
      end
      LOAD_HI: begin
        sready = 1'b1;
        if (bus.SVALID) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        wenable = 1'b1;
        if (lastWord) begin
          state_d = VERIFY ? RD_ISSUE : FINISH;
        end else begin
          state_d = LOAD_LO;
        end
      end
      RD_ISSUE: begin
        renable = 1'b1;
        if (lastRead) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        state_d = FINISH;
      end
      FINISH: begin
        finishing = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A rejected word count never leaves IDLE; its DONE/ERROR come from baddone_q.
  always_ff @(posedge RWCLK or posedge RESET) begin
    if (RESET) begin
      words_q    <= '0;
      n_q        <= '0;
      lo_q       <= '0;
      initaddr_q <= '0;
      initdata_q <= '0;
      raddr_q    <= '0;
      rdvalid_q  <= 1'b0;
      baddone_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      baddone_q <= 1'b0;
      rdvalid_q <= renable;
      case (state_q)
        IDLE: begin
          if (bus.START) begin
            words_q   <= bus.WORDS;
            n_q       <= '0;
            err_q     <= ~wordsLegal;
            baddone_q <= ~wordsLegal;
          end
        end
        LOAD_LO: begin
          if (bus.SVALID) begin
            lo_q <= bus.SDATA;
          end
        end
        LOAD_HI: begin
          if (bus.SVALID) begin
            initaddr_q <= n_q[AWIDTH-1:0];
            initdata_q <= {bus.SDATA[0], lo_q};
          end
        end
        WRITE: begin
          if (lastWord) begin
            if (VERIFY) begin
              raddr_q <= '0;
            end
          end else begin
            n_q <= n_q + N_ONE;
          end
        end
        RD_ISSUE: begin
          if (!lastRead) begin
            raddr_q <= raddr_q + RA_ONE;
          end
        end
        FINISH: begin
          if (verifyFail) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  iram_csum16 u_wsum (
    .clk   (RWCLK),
    .rst   (RESET),
    .clr_i (startAccept),
    .acc_i (wenable),
    .data_i({{(CSUM_WIDTH-DWIDTH){1'b0}}, initdata_q}),
    .sum_o (wsum)
  );

  // Readback data arrives one cycle after each read, hence rdvalid_q.
  iram_csum16 u_rsum (
    .clk   (RWCLK),
    .rst   (RESET),
    .clr_i (startAccept),
    .acc_i (rdvalid_q),
    .data_i({{(CSUM_WIDTH-DWIDTH){1'b0}}, bus.RD}),
    .sum_o (rsum)
  );

  assign bus.SREADY   = sready;
  assign bus.WENABLE  = wenable;
  assign bus.RENABLE  = renable;
  assign bus.INITADDR = initaddr_q;
  assign bus.INITDATA = initdata_q;
  assign bus.RADDR    = raddr_q;
  assign bus.BUSY     = (state_q != IDLE);
  assign bus.DONE     = finishing | baddone_q;
  assign bus.ERROR    = err_q | (finishing & verifyFail);
  assign bus.CHECKSUM = wsum;

endmodule

// File: tb/tb_iram_init_loader.sv
// Directed and randomized bench for iram_init_loader with a behavioural RAM
// and a word/checksum model derived from the byte stream.
module tb_iram_init_loader;
  import iram_loader_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iram_init_loader_if #(.AWIDTH(9), .DWIDTH(9)) bus ();

  iram_init_loader #(.AWIDTH(9), .DWIDTH(9), .VERIFY(1'b1)) dut (
    .RWCLK(clk),
    .RESET(rst),
    .bus  (bus)
  );

  logic [8:0] mem [512];
  logic [8:0] rdReg = '0;
  bit         corruptEn = 1'b0;
  int         corruptAddr = 0;

  always @(posedge clk) begin
    if (bus.WENABLE) mem[bus.INITADDR] <= bus.INITDATA;
    if (bus.RENABLE)
      rdReg <= mem[bus.RADDR] ^ ((corruptEn && int'(bus.RADDR) == corruptAddr) ? 9'h001 : 9'h000);
  end
  assign bus.RD = rdReg;

  int   cycle = 0;
  int   wrAddr[$], wrData[$], wrCyc[$], rdAddr[$], rdCyc[$];
  int   doneCount = 0;
  int   overlapCount = 0;
  logic errAtDone = 1'b0;

  // Log RAM traffic and DONE just after each edge, when outputs are settled.
  always @(posedge clk) begin
    #1;
    cycle++;
    if (bus.WENABLE) begin
      wrAddr.push_back(int'(bus.INITADDR));
      wrData.push_back(int'(bus.INITDATA));
      wrCyc.push_back(cycle);
    end
    if (bus.RENABLE) begin
      rdAddr.push_back(int'(bus.RADDR));
      rdCyc.push_back(cycle);
    end
    if (bus.WENABLE && bus.RENABLE) overlapCount++;
    if (bus.DONE) begin
      doneCount++;
      errAtDone = bus.ERROR;
    end
  end

  int         checks = 0;
  int         passes = 0;
  int         fails  = 0;
  logic [7:0] txBytes[$];
  int         wrBase, rdBase, doneBase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic markLog();
    wrBase   = wrAddr.size();
    rdBase   = rdAddr.size();
    doneBase = doneCount;
  endtask

  task automatic startOp(input int w);
    @(negedge clk);
    bus.START = 1'b1;
    bus.WORDS = w[9:0];
    @(negedge clk);
    bus.START = 1'b0;
  endtask

  // mode 0: SVALID always high, 1: toggling, 2: random
  task automatic applyStimulus(input int mode, input bit midStart);
    int idx = 0;
    int cyc = 0;
    while (doneCount == doneBase && cyc < 5000) begin
      if (idx < txBytes.size()) begin
        bus.SVALID = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom);
        bus.SDATA  = txBytes[idx];
      end else begin
        bus.SVALID = 1'b0;
        bus.SDATA  = 8'($urandom);
      end
      if (midStart && cyc == 7) begin
        bus.START = 1'b1;
        bus.WORDS = 10'd7;
      end else begin
        bus.START = 1'b0;
      end
      if (bus.SVALID && bus.SREADY) idx++;
      @(negedge clk);
      cyc++;
    end
    bus.SVALID = 1'b0;
    bus.START  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int w, input bit expErr, input bit continuous);
    int expW[$];
    int expSum = 0;
    for (int i = 0; i < w; i++) begin
      expW.push_back({23'd0, txBytes[2*i+1][0], txBytes[2*i]});
      expSum = (expSum + expW[i]) % 65536;
    end
    check({name, ".wcount"}, wrAddr.size() - wrBase, w);
    for (int i = 0; i < w && wrBase + i < wrAddr.size(); i++) begin
      check({name, ".waddr"}, wrAddr[wrBase+i], i);
      check({name, ".wdata"}, wrData[wrBase+i], expW[i]);
      check({name, ".mem"}, {23'd0, mem[i]}, expW[i]);
      if (continuous && i > 0) check({name, ".wgap"}, wrCyc[wrBase+i] - wrCyc[wrBase+i-1], 3);
    end
    check({name, ".rcount"}, rdAddr.size() - rdBase, w);
    for (int i = 0; i < w && rdBase + i < rdAddr.size(); i++) begin
      check({name, ".raddr"}, rdAddr[rdBase+i], i);
      if (i > 0) check({name, ".rgap"}, rdCyc[rdBase+i] - rdCyc[rdBase+i-1], 1);
    end
    check({name, ".csum"}, {16'd0, bus.CHECKSUM}, expSum);
    check({name, ".done"}, doneCount - doneBase, 1);
    check({name, ".errAtDone"}, {31'd0, errAtDone}, {31'd0, expErr});
    check({name, ".errHeld"}, {31'd0, bus.ERROR}, {31'd0, expErr});
    check({name, ".busyEnd"}, {31'd0, bus.BUSY}, 0);
    check({name, ".overlap"}, overlapCount, 0);
  endtask

  task automatic checkAllZero(input string name);
    check({name, ".sready"}, {31'd0, bus.SREADY}, 0);
    check({name, ".wen"}, {31'd0, bus.WENABLE}, 0);
    check({name, ".ren"}, {31'd0, bus.RENABLE}, 0);
    check({name, ".busy"}, {31'd0, bus.BUSY}, 0);
    check({name, ".done"}, {31'd0, bus.DONE}, 0);
    check({name, ".error"}, {31'd0, bus.ERROR}, 0);
    check({name, ".initaddr"}, {23'd0, bus.INITADDR}, 0);
    check({name, ".initdata"}, {23'd0, bus.INITDATA}, 0);
    check({name, ".raddr"}, {23'd0, bus.RADDR}, 0);
    check({name, ".csum"}, {16'd0, bus.CHECKSUM}, 0);
  endtask

  task automatic badWords(input int w);
    markLog();
    startOp(w);
    check("bad.errEarly", {31'd0, bus.ERROR}, 1);
    repeat (4) @(negedge clk);
    check("bad.wcount", wrAddr.size() - wrBase, 0);
    check("bad.rcount", rdAddr.size() - rdBase, 0);
    check("bad.done", doneCount - doneBase, 1);
    check("bad.errAtDone", {31'd0, errAtDone}, 1);
    check("bad.busy", {31'd0, bus.BUSY}, 0);
    check("bad.csum", {16'd0, bus.CHECKSUM}, 0);
  endtask

  initial begin
    int idx;
    int guard;
    int w;
    rst        = 1'b1;
    bus.START  = 1'b0;
    bus.WORDS  = '0;
    bus.SDATA  = '0;
    bus.SVALID = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkAllZero("reset");

    // Directed three-word load with continuous stream
    txBytes = {8'h34, 8'h01, 8'hFF, 8'h00, 8'h00, 8'hFE};
    markLog();
    startOp(3);
    applyStimulus(0, 1'b0);
    checkOutput("t1", 3, 1'b0, 1'b1);

    // Same load, RAM corrupts word 1 on readback
    corruptEn = 1'b1;
    corruptAddr = 1;
    markLog();
    startOp(3);
    applyStimulus(0, 1'b0);
    corruptEn = 1'b0;
    checkOutput("corrupt", 3, 1'b1, 1'b1);

    // Full-depth load, data = address
    txBytes = {};
    for (int a = 0; a < 512; a++) begin
      txBytes.push_back(8'(a));
      txBytes.push_back({7'($urandom), a[8]});
    end
    markLog();
    startOp(512);
    applyStimulus(0, 1'b0);
    checkOutput("full", 512, 1'b0, 1'b1);

    // Illegal counts, then a legal START clears ERROR
    badWords(0);
    badWords(600);
    txBytes = {8'h12, 8'h01, 8'h9C, 8'h00};
    markLog();
    startOp(2);
    check("clr.error", {31'd0, bus.ERROR}, 0);
    check("clr.busy", {31'd0, bus.BUSY}, 1);
    check("clr.csum", {16'd0, bus.CHECKSUM}, 0);
    applyStimulus(0, 1'b0);
    checkOutput("clr", 2, 1'b0, 1'b1);

    // Toggling SVALID with an ignored START mid-load
    txBytes = {};
    for (int i = 0; i < 10; i++) txBytes.push_back(8'($urandom));
    markLog();
    startOp(5);
    applyStimulus(1, 1'b1);
    checkOutput("toggle", 5, 1'b0, 1'b0);

    // Randomized loads
    for (int r = 0; r < 4; r++) begin
      w = $urandom_range(16, 1);
      txBytes = {};
      for (int i = 0; i < 2 * w; i++) txBytes.push_back(8'($urandom));
      markLog();
      startOp(w);
      applyStimulus(2, 1'b0);
      checkOutput("rand", w, 1'b0, 1'b0);
    end

    // Async reset while waiting for the high byte of word 2
    txBytes = {8'h5A, 8'h01, 8'hC3, 8'h01, 8'h77, 8'h01, 8'h11, 8'h00};
    markLog();
    startOp(4);
    idx = 0;
    guard = 0;
    while (idx < 5 && guard < 50) begin
      bus.SVALID = 1'b1;
      bus.SDATA  = txBytes[idx];
      if (bus.SREADY) idx++;
      @(negedge clk);
      guard++;
    end
    bus.SVALID = 1'b0;
    check("mid.bytes", idx, 5);
    check("mid.sready", {31'd0, bus.SREADY}, 1);
    check("mid.initaddr", {23'd0, bus.INITADDR}, 1);
    #2 rst = 1'b1;
    #1 checkAllZero("asyncReset");
    @(negedge clk);
    rst = 1'b0;
    txBytes = {8'($urandom), 8'($urandom)};
    markLog();
    startOp(1);
    applyStimulus(0, 1'b0);
    checkOutput("afterReset", 1, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
